multicycle_control_fsm: RTL and testbench

Moore-style sequencing controller for the multi-cycle variant of the MIPS core. One shared memory serves both instruction fetch and data access. The controller decodes the latched opcode and steps the datapath through FETCH/DECODE/execute/writeback states, driving every mux select, write enable and ALUOp. It stalls on a memory-ready handshake and keeps a retired-instruction counter for bring-up and performance checks.

---
 rtl/multicycle_control_fsm_if.sv | 39 +++
 rtl/multicycle_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_control_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          opcode;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSource;
    logic [3:0]          state;
    logic                instr_done;
    logic                illegal_op;
    logic [RETIRE_W-1:0] retire_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, retire_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, retire_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multi-cycle MIPS core with a shared
// instruction/data memory, memory-ready stalls and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int RETIRE_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t              state_q;
    logic [RETIRE_W-1:0] retire_q;
    logic                rdy;
    logic                instr_done_c;
    logic                illegal_c;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_is_legal = 1'b1;
            default:                                      op_is_legal = 1'b0;
        endcase
    endfunction

    assign rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

    // A store retires on its final (ready) MEMWR cycle; every other class retires
    // in its single terminal state.
    always_comb begin
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        if (rst) begin
            case (state_q)
                MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: instr_done_c = 1'b1;
                MEMWR:                              instr_done_c = rdy;
                DECODE:                             illegal_c    = !op_is_legal(bus.opcode);
                default:                            instr_done_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            retire_q <= '0;
        end else begin
            if (instr_done_c) begin
                retire_q <= retire_q + RETIRE_W'(1);
            end
            case (state_q)
                FETCH: begin
                    if (rdy) state_q <= DECODE;
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXEC;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_ADDI:      state_q <= ADDIEX;
                        OP_J:         state_q <= JUMP;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR: state_q <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (rdy) state_q <= MEMWB;
                end
                MEMWR: begin
                    if (rdy) state_q <= FETCH;
                end
                EXEC:    state_q <= ALUWB;
                ADDIEX:  state_q <= ADDIWB;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Controls decode straight from the state so an asserted reset kills any
    // in-flight memory request without waiting for a clock edge.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        if (rst) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = rdy;
                    bus.PCWrite = rdy;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                end
                MEMADR, ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                ADDIWB: begin
                    bus.RegWrite = 1'b1;
                end
                JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                default: begin
                    bus.PCWrite = 1'b0;
                end
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.instr_done   = instr_done_c;
    assign bus.illegal_op   = illegal_c;
    assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;

    localparam int RW = 4;

    // Packing: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    // RegWrite,ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2]
    localparam logic [15:0] C_ZERO   = 16'h0000;
    localparam logic [15:0] C_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [15:0] C_FSTALL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [15:0] C_DECODE = {10'b0,2'b11,2'b00,2'b00};
    localparam logic [15:0] C_ADDR   = {9'b0,1'b1,2'b10,2'b00,2'b00};
    localparam logic [15:0] C_MEMRD  = {2'b00,1'b1,1'b1,12'b0};
    localparam logic [15:0] C_MEMWR  = {2'b00,1'b1,1'b0,1'b1,11'b0};
    localparam logic [15:0] C_MEMWB  = {6'b0,1'b1,1'b0,1'b1,7'b0};
    localparam logic [15:0] C_EXEC   = {9'b0,1'b1,2'b00,2'b10,2'b00};
    localparam logic [15:0] C_ALUWB  = {6'b0,1'b0,1'b1,1'b1,7'b0};
    localparam logic [15:0] C_BRANCH = {1'b0,1'b1,7'b0,1'b1,2'b00,2'b01,2'b01};
    localparam logic [15:0] C_ADDIWB = {8'b0,1'b1,7'b0};
    localparam logic [15:0] C_JUMP   = {1'b1,13'b0,2'b10};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        string      label;
        logic [3:0] st;
        logic [15:0] ctl;
        logic       done;
        logic       ill;
        logic [RW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    multicycle_control_fsm_if #(.RETIRE_W(RW)) bus ();

    multicycle_control_fsm #(
        .USE_MEM_READY(1'b1),
        .RETIRE_W     (RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [25:0] pack_dut();
        pack_dut = {bus.state,
                    bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                    bus.instr_done, bus.illegal_op, bus.retire_count};
    endfunction

    task automatic checkOutput(input string label, input logic [25:0] act, input logic [25:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual={st=%0d ctl=%h done=%b ill=%b cnt=%0d} required={st=%0d ctl=%h done=%b ill=%b cnt=%0d}",
                     label, act[25:22], act[21:6], act[5], act[4], act[3:0],
                     req[25:22], req[21:6], req[5], req[4], req[3:0]);
        end
    endtask

    // One clock period per call: drive inputs just after the edge, queue what the
    // DUT must show at the following negedge.
    task automatic applyStimulus(input string label, input logic r, input logic [5:0] op,
                                 input logic rdy, input logic [3:0] st, input logic [15:0] ctl,
                                 input logic done, input logic ill, input logic [RW-1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        e.label = label;
        e.st    = st;
        e.ctl   = ctl;
        e.done  = done;
        e.ill   = ill;
        e.cnt   = cnt;
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e.label, pack_dut(), {e.st, e.ctl, e.done, e.ill, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus("reset", 0, OP_R, 1, 0, C_ZERO, 0, 0, 0);

        // lw, no wait states
        applyStimulus("lw_fetch",  1, OP_LW, 1, 0, C_FETCH,  0, 0, 0);
        applyStimulus("lw_decode", 1, OP_LW, 1, 1, C_DECODE, 0, 0, 0);
        applyStimulus("lw_memadr", 1, OP_LW, 1, 2, C_ADDR,   0, 0, 0);
        applyStimulus("lw_memrd",  1, OP_LW, 1, 3, C_MEMRD,  0, 0, 0);
        applyStimulus("lw_memwb",  1, OP_LW, 1, 4, C_MEMWB,  1, 0, 0);

        // sw with two MEMWR stall cycles
        applyStimulus("sw_fetch",  1, OP_SW, 1, 0, C_FETCH,  0, 0, 1);
        applyStimulus("sw_decode", 1, OP_SW, 1, 1, C_DECODE, 0, 0, 1);
        applyStimulus("sw_memadr", 1, OP_SW, 1, 2, C_ADDR,   0, 0, 1);
        applyStimulus("sw_wait1",  1, OP_SW, 0, 5, C_MEMWR,  0, 0, 1);
        applyStimulus("sw_wait2",  1, OP_SW, 0, 5, C_MEMWR,  0, 0, 1);
        applyStimulus("sw_done",   1, OP_SW, 1, 5, C_MEMWR,  1, 0, 1);

        applyStimulus("r_fetch",   1, OP_R, 1, 0, C_FETCH,  0, 0, 2);
        applyStimulus("r_decode",  1, OP_R, 1, 1, C_DECODE, 0, 0, 2);
        applyStimulus("r_exec",    1, OP_R, 1, 6, C_EXEC,   0, 0, 2);
        applyStimulus("r_aluwb",   1, OP_R, 1, 7, C_ALUWB,  1, 0, 2);

        applyStimulus("beq_fetch", 1, OP_BEQ, 1, 0, C_FETCH,  0, 0, 3);
        applyStimulus("beq_dec",   1, OP_BEQ, 1, 1, C_DECODE, 0, 0, 3);
        applyStimulus("beq_br",    1, OP_BEQ, 1, 8, C_BRANCH, 1, 0, 3);

        applyStimulus("j_fetch",   1, OP_J, 1, 0,  C_FETCH,  0, 0, 4);
        applyStimulus("j_decode",  1, OP_J, 1, 1,  C_DECODE, 0, 0, 4);
        applyStimulus("j_jump",    1, OP_J, 1, 11, C_JUMP,   1, 0, 4);

        applyStimulus("addi_fetch", 1, OP_ADI, 1, 0,  C_FETCH,  0, 0, 5);
        applyStimulus("addi_dec",   1, OP_ADI, 1, 1,  C_DECODE, 0, 0, 5);
        applyStimulus("addi_ex",    1, OP_ADI, 1, 9,  C_ADDR,   0, 0, 5);
        applyStimulus("addi_wb",    1, OP_ADI, 1, 10, C_ADDIWB, 1, 0, 5);

        // Fetch stall, then an illegal opcode that must not retire
        applyStimulus("fetch_stall", 1, OP_BAD, 0, 0, C_FSTALL, 0, 0, 6);
        applyStimulus("bad_fetch",   1, OP_BAD, 1, 0, C_FETCH,  0, 0, 6);
        applyStimulus("bad_decode",  1, OP_BAD, 1, 1, C_DECODE, 0, 1, 6);

        // lw with one MEMRD stall cycle
        applyStimulus("lw2_fetch",  1, OP_LW, 1, 0, C_FETCH,  0, 0, 6);
        applyStimulus("lw2_decode", 1, OP_LW, 1, 1, C_DECODE, 0, 0, 6);
        applyStimulus("lw2_memadr", 1, OP_LW, 1, 2, C_ADDR,   0, 0, 6);
        applyStimulus("lw2_wait",   1, OP_LW, 0, 3, C_MEMRD,  0, 0, 6);
        applyStimulus("lw2_memrd",  1, OP_LW, 1, 3, C_MEMRD,  0, 0, 6);
        applyStimulus("lw2_memwb",  1, OP_LW, 1, 4, C_MEMWB,  1, 0, 6);

        // Reset dropped while a store is stalled in MEMWR
        applyStimulus("sw3_fetch",  1, OP_SW, 1, 0, C_FETCH,  0, 0, 7);
        applyStimulus("sw3_decode", 1, OP_SW, 1, 1, C_DECODE, 0, 0, 7);
        applyStimulus("sw3_memadr", 1, OP_SW, 1, 2, C_ADDR,   0, 0, 7);
        applyStimulus("sw3_wait",   1, OP_SW, 0, 5, C_MEMWR,  0, 0, 7);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", pack_dut(), {4'd0, C_ZERO, 1'b0, 1'b0, 4'd0});
        applyStimulus("reset_hold", 0, OP_J, 1, 0, C_ZERO, 0, 0, 0);

        // Sixteen jumps take the 4-bit counter through 15 and back to 0
        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("wrap_f%0d", i), 1, OP_J, 1, 0,  C_FETCH,  0, 0, i[RW-1:0]);
            applyStimulus($sformatf("wrap_d%0d", i), 1, OP_J, 1, 1,  C_DECODE, 0, 0, i[RW-1:0]);
            applyStimulus($sformatf("wrap_j%0d", i), 1, OP_J, 1, 11, C_JUMP,   1, 0, i[RW-1:0]);
        end
        applyStimulus("wrap_zero", 1, OP_J, 1, 0, C_FETCH, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0 entries left", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
